// File: rtl/ps_chain.sv
// ps_chain: runtime-programmable header-chain parser.
// Walks a chain of up to NUM_HDR_TYPES header types through a captured
// HDR_MAX_LEN-byte window, one header per clock, starting at type 0, offset 0.
// Each type has a length, a tag location (start, 0/1/2 bytes, big-endian) and
// a next-header table of {tag[15:0], next_id[15:0]} entries.
//
// Optional feature: define PS_CFG_SHADOW_EN to add a shadow configuration
// bank that is written at any time and copied to the active bank by
// cfg_commit_i while idle (a commit arriving while busy is held pending).
// Without it, cfg_we_i writes the active bank directly, and only while idle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i, pkt_hdr_i  parse request and header window (byte 0 first on wire)
//   ready_o             idle, start_i accepted
//   done_o              one-cycle result-valid pulse
//   err_o               last parse overran the window
//   hdr_valid_o         mask of header types found
//   hdr_off_o           byte offset of each header type found
//   end_off_o           first byte after the last header
//   cfg_*               configuration write port and commit strobe
module ps_chain #(
  parameter int unsigned HDR_MAX_LEN     = 64,
  parameter int unsigned NUM_HDR_TYPES   = 8,
  parameter int unsigned NEXT_TABLE_SIZE = 2,
  localparam int unsigned IW = $clog2(NUM_HDR_TYPES),
  localparam int unsigned OW = $clog2(HDR_MAX_LEN + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [HDR_MAX_LEN-1:0][7:0]            pkt_hdr_i,
  output logic                                   ready_o,
  output logic                                   done_o,
  output logic                                   err_o,
  output logic [NUM_HDR_TYPES-1:0]               hdr_valid_o,
  output logic [NUM_HDR_TYPES-1:0][OW-1:0]       hdr_off_o,
  output logic [OW-1:0]                          end_off_o,
  input  logic                                   cfg_we_i,
  input  logic [IW-1:0]                          cfg_hdr_id_i,
  input  logic [OW-1:0]                          cfg_hdr_len_i,
  input  logic [OW-1:0]                          cfg_tag_start_i,
  input  logic [1:0]                             cfg_tag_len_i,
  input  logic [NEXT_TABLE_SIZE-1:0][31:0]       cfg_next_table_i,
  input  logic                                   cfg_commit_i
);

  localparam logic [OW:0] MaxLen = (OW+1)'(HDR_MAX_LEN);

  typedef enum logic [1:0] {StIdle, StParse, StDone} state_e;

  state_e                              state_q;
  logic                                idle;
  logic [HDR_MAX_LEN-1:0][7:0]         pkt_q;
  logic [IW-1:0]                       cur_q;
  logic [OW-1:0]                       cur_off_q;

  // Active configuration bank, the only one the parse reads.
  logic [OW-1:0]                       act_len_q       [NUM_HDR_TYPES];
  logic [OW-1:0]                       act_tag_start_q [NUM_HDR_TYPES];
  logic [1:0]                          act_tag_len_q   [NUM_HDR_TYPES];
  logic [NEXT_TABLE_SIZE-1:0][31:0]    act_next_q      [NUM_HDR_TYPES];

  logic                                cfg_id_ok;

  assign idle      = (state_q == StIdle);
  assign cfg_id_ok = (int'(cfg_hdr_id_i) < int'(NUM_HDR_TYPES));

`ifdef PS_CFG_SHADOW_EN
  logic [OW-1:0]                       shd_len_q       [NUM_HDR_TYPES];
  logic [OW-1:0]                       shd_tag_start_q [NUM_HDR_TYPES];
  logic [1:0]                          shd_tag_len_q   [NUM_HDR_TYPES];
  logic [NEXT_TABLE_SIZE-1:0][31:0]    shd_next_q      [NUM_HDR_TYPES];
  logic                                pending_q;
  logic                                commit_now;

  assign commit_now = idle && (cfg_commit_i || pending_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < int'(NUM_HDR_TYPES); t++) begin
        shd_len_q[t]       <= '0;
        shd_tag_start_q[t] <= '0;
        shd_tag_len_q[t]   <= '0;
        act_len_q[t]       <= '0;
        act_tag_start_q[t] <= '0;
        act_tag_len_q[t]   <= '0;
        for (int e = 0; e < int'(NEXT_TABLE_SIZE); e++) begin
          shd_next_q[t][e] <= 32'h0000_FFFF;
          act_next_q[t][e] <= 32'h0000_FFFF;
        end
      end
      pending_q <= 1'b0;
    end else begin
      if (commit_now) begin
        act_len_q       <= shd_len_q;
        act_tag_start_q <= shd_tag_start_q;
        act_tag_len_q   <= shd_tag_len_q;
        act_next_q      <= shd_next_q;
      end
      if (cfg_we_i && cfg_id_ok) begin
        shd_len_q[cfg_hdr_id_i]       <= cfg_hdr_len_i;
        shd_tag_start_q[cfg_hdr_id_i] <= cfg_tag_start_i;
        shd_tag_len_q[cfg_hdr_id_i]   <= cfg_tag_len_i;
        shd_next_q[cfg_hdr_id_i]      <= cfg_next_table_i;
        // A write landing with the commit is part of what gets committed.
        if (commit_now) begin
          act_len_q[cfg_hdr_id_i]       <= cfg_hdr_len_i;
          act_tag_start_q[cfg_hdr_id_i] <= cfg_tag_start_i;
          act_tag_len_q[cfg_hdr_id_i]   <= cfg_tag_len_i;
          act_next_q[cfg_hdr_id_i]      <= cfg_next_table_i;
        end
      end
      if (idle) begin
        pending_q <= 1'b0;
      end else if (cfg_commit_i) begin
        pending_q <= 1'b1;
      end
    end
  end
`else
  logic unused_commit;
  assign unused_commit = cfg_commit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < int'(NUM_HDR_TYPES); t++) begin
        act_len_q[t]       <= '0;
        act_tag_start_q[t] <= '0;
        act_tag_len_q[t]   <= '0;
        for (int e = 0; e < int'(NEXT_TABLE_SIZE); e++) begin
          act_next_q[t][e] <= 32'h0000_FFFF;
        end
      end
    end else if (cfg_we_i && cfg_id_ok && idle) begin
      act_len_q[cfg_hdr_id_i]       <= cfg_hdr_len_i;
      act_tag_start_q[cfg_hdr_id_i] <= cfg_tag_start_i;
      act_tag_len_q[cfg_hdr_id_i]   <= cfg_tag_len_i;
      act_next_q[cfg_hdr_id_i]      <= cfg_next_table_i;
    end
  end
`endif

  // Byte read that yields zero outside the window.
  function automatic logic [7:0] get_byte(input logic [HDR_MAX_LEN-1:0][7:0] p,
                                          input logic [OW:0] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < int'(HDR_MAX_LEN); i++) begin
      if (idx == (OW+1)'(i)) b = p[i];
    end
    return b;
  endfunction

  logic [OW:0]              len, sum, tstart, tag_abs;
  logic [1:0]               tlen;
  logic                     overrun, has_tag, hit, advance;
  logic [7:0]               b0, b1;
  logic [15:0]              tag;
  logic [IW-1:0]            nid;
  logic [NUM_HDR_TYPES-1:0] seen;

  always_comb begin
    len     = {1'b0, act_len_q[cur_q]};
    sum     = {1'b0, cur_off_q} + len;
    overrun = (sum > MaxLen);
    tlen    = act_tag_len_q[cur_q];
    tstart  = {1'b0, act_tag_start_q[cur_q]};
    tag_abs = {1'b0, cur_off_q} + tstart;
    // Tag must sit wholly inside the header; header is inside the window
    // whenever the result is used, so the window check is implied.
    has_tag = ((tlen == 2'd1) || (tlen == 2'd2)) &&
              ((tstart + {{(OW-1){1'b0}}, tlen}) <= len);
    b0      = get_byte(pkt_q, tag_abs);
    b1      = get_byte(pkt_q, tag_abs + (OW+1)'(1));
    tag     = (tlen == 2'd2) ? {b0, b1} : {8'h00, b0};
    hit     = 1'b0;
    nid     = '0;
    // Descending scan so the lowest-numbered matching entry wins.
    for (int e = int'(NEXT_TABLE_SIZE) - 1; e >= 0; e--) begin
      if (has_tag && (act_next_q[cur_q][e][15:0] < 16'(NUM_HDR_TYPES)) &&
          (act_next_q[cur_q][e][31:16] == tag)) begin
        hit = 1'b1;
        nid = act_next_q[cur_q][e][IW-1:0];
      end
    end
    // The current type counts as seen even though its bit lands this edge.
    seen    = hdr_valid_o | (NUM_HDR_TYPES'(1) << cur_q);
    advance = hit && !seen[nid] && (sum < MaxLen);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      hdr_valid_o <= '0;
      hdr_off_o   <= '0;
      end_off_o   <= '0;
      pkt_q       <= '0;
      cur_q       <= '0;
      cur_off_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            pkt_q       <= pkt_hdr_i;
            hdr_valid_o <= '0;
            hdr_off_o   <= '0;
            err_o       <= 1'b0;
            cur_q       <= '0;
            cur_off_q   <= '0;
            ready_o     <= 1'b0;
            state_q     <= StParse;
          end
        end
        StParse: begin
          if (overrun) begin
            err_o   <= 1'b1;
            done_o  <= 1'b1;
            state_q <= StDone;
          end else begin
            hdr_valid_o[cur_q] <= 1'b1;
            hdr_off_o[cur_q]   <= cur_off_q;
            end_off_o          <= sum[OW-1:0];
            if (advance) begin
              cur_q     <= nid;
              cur_off_q <= sum[OW-1:0];
            end else begin
              done_o  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps_chain.sv
module tb_ps_chain;

  localparam int HL = 64;
  localparam int NT = 8;
  localparam int NS = 2;
  localparam int IW = 3;
  localparam int OW = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_i;
  logic [HL-1:0][7:0]      pkt_hdr_i;
  logic                    ready_o, done_o, err_o;
  logic [NT-1:0]           hdr_valid_o;
  logic [NT-1:0][OW-1:0]   hdr_off_o;
  logic [OW-1:0]           end_off_o;
  logic                    cfg_we_i;
  logic [IW-1:0]           cfg_hdr_id_i;
  logic [OW-1:0]           cfg_hdr_len_i, cfg_tag_start_i;
  logic [1:0]              cfg_tag_len_i;
  logic [NS-1:0][31:0]     cfg_next_table_i;
  logic                    cfg_commit_i;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ps_chain dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .pkt_hdr_i        (pkt_hdr_i),
    .ready_o          (ready_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .hdr_valid_o      (hdr_valid_o),
    .hdr_off_o        (hdr_off_o),
    .end_off_o        (end_off_o),
    .cfg_we_i         (cfg_we_i),
    .cfg_hdr_id_i     (cfg_hdr_id_i),
    .cfg_hdr_len_i    (cfg_hdr_len_i),
    .cfg_tag_start_i  (cfg_tag_start_i),
    .cfg_tag_len_i    (cfg_tag_len_i),
    .cfg_next_table_i (cfg_next_table_i),
    .cfg_commit_i     (cfg_commit_i)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg_write(input int id, input int len, input int ts, input int tl,
                           input logic [31:0] e0, input logic [31:0] e1);
    cfg_we_i            = 1'b1;
    cfg_hdr_id_i        = IW'(id);
    cfg_hdr_len_i       = OW'(len);
    cfg_tag_start_i     = OW'(ts);
    cfg_tag_len_i       = 2'(tl);
    cfg_next_table_i[0] = e0;
    cfg_next_table_i[1] = e1;
    cfg_commit_i        = 1'b1;
    @(posedge clk); #1;
    cfg_we_i     = 1'b0;
    cfg_commit_i = 1'b0;
  endtask

  task automatic program_eth(input int len2, input logic [31:0] t1e0);
    cfg_write(0, 14, 12, 2, 32'h0800_0001, 32'h0000_FFFF);
    cfg_write(1, 20, 9, 1, t1e0, 32'h0000_FFFF);
    cfg_write(2, len2, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF);
  endtask

  task automatic set_pkt(input logic [15:0] etype);
    pkt_hdr_i     = '0;
    pkt_hdr_i[12] = etype[15:8];
    pkt_hdr_i[13] = etype[7:0];
    pkt_hdr_i[14] = 8'h45;
    pkt_hdr_i[23] = 8'h06;
    pkt_hdr_i[34] = 8'h06; // would mislead a parser reading the wrong offset
  endtask

  task automatic start_pkt();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Returns cycles from the start cycle T to the done_o cycle, then steps into IDLE.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (done_o !== 1'b1) $display("FAIL done_timeout: done_o=%b required 1", done_o);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({done_o, ready_o} !== 2'b01)
      $display("FAIL done_pulse: done_o,ready_o=%b required 01", {done_o, ready_o});
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) $display("FAIL rst_ready: %b required 1", ready_o);
    else passed++;
    checks++; if (done_o !== 1'b0) $display("FAIL rst_done: %b required 0", done_o);
    else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL rst_err: %b required 0", err_o);
    else passed++;
    checks++; if (hdr_valid_o !== 8'h00) $display("FAIL rst_valid: %h required 00", hdr_valid_o);
    else passed++;
    checks++; if (hdr_off_o !== '0) $display("FAIL rst_off: %h required 0", hdr_off_o);
    else passed++;
    checks++; if (end_off_o !== 7'd0) $display("FAIL rst_end: %0d required 0", end_off_o);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_chain();
    int lat;
    set_pkt(16'h0800);
    start_pkt();
    wait_done(lat);
    checks++; if (lat !== 4) $display("FAIL chain_lat: %0d required 4", lat);
    else passed++;
    checks++; if (hdr_valid_o !== 8'b0000_0111)
      $display("FAIL chain_valid: %b required 00000111", hdr_valid_o);
    else passed++;
    checks++; if (hdr_off_o[0] !== 7'd0) $display("FAIL chain_off0: %0d required 0", hdr_off_o[0]);
    else passed++;
    checks++; if (hdr_off_o[1] !== 7'd14)
      $display("FAIL chain_off1: %0d required 14", hdr_off_o[1]);
    else passed++;
    checks++; if (hdr_off_o[2] !== 7'd34)
      $display("FAIL chain_off2: %0d required 34", hdr_off_o[2]);
    else passed++;
    checks++; if (end_off_o !== 7'd54) $display("FAIL chain_end: %0d required 54", end_off_o);
    else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL chain_err: %b required 0", err_o);
    else passed++;
  endtask

  task automatic test_overrun();
    int lat;
    cfg_write(2, 40, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF);
    set_pkt(16'h0800);
    start_pkt();
    wait_done(lat);
    checks++; if (err_o !== 1'b1) $display("FAIL ovr_err: %b required 1", err_o);
    else passed++;
    checks++; if (hdr_valid_o !== 8'b0000_0011)
      $display("FAIL ovr_valid: %b required 00000011", hdr_valid_o);
    else passed++;
    checks++; if (end_off_o !== 7'd34) $display("FAIL ovr_end: %0d required 34", end_off_o);
    else passed++;
    cfg_write(2, 20, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF);
  endtask

  task automatic test_loop_guard();
    int lat;
    cfg_write(1, 20, 9, 1, 32'h0006_0001, 32'h0000_FFFF);
    set_pkt(16'h0800);
    start_pkt();
    wait_done(lat);
    checks++; if (lat !== 3) $display("FAIL loop_lat: %0d required 3", lat);
    else passed++;
    checks++; if (hdr_valid_o !== 8'b0000_0011)
      $display("FAIL loop_valid: %b required 00000011", hdr_valid_o);
    else passed++;
    checks++; if (end_off_o !== 7'd34) $display("FAIL loop_end: %0d required 34", end_off_o);
    else passed++;
    cfg_write(1, 20, 9, 1, 32'h0006_0002, 32'h0000_FFFF);
  endtask

  task automatic test_no_match();
    int lat;
    set_pkt(16'h86DD);
    start_pkt();
    wait_done(lat);
    checks++; if (lat !== 2) $display("FAIL nomatch_lat: %0d required 2", lat);
    else passed++;
    checks++; if (hdr_valid_o !== 8'b0000_0001)
      $display("FAIL nomatch_valid: %b required 00000001", hdr_valid_o);
    else passed++;
    checks++; if (end_off_o !== 7'd14) $display("FAIL nomatch_end: %0d required 14", end_off_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic saw_done;
    set_pkt(16'h0800);
    start_pkt();            // now in T+1
    @(posedge clk); #1;     // T+2
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({ready_o, done_o, err_o} !== 3'b100)
      $display("FAIL rmid_ctrl: ready,done,err=%b required 100", {ready_o, done_o, err_o});
    else passed++;
    checks++; if (hdr_valid_o !== 8'h00 || end_off_o !== 7'd0 || hdr_off_o !== '0)
      $display("FAIL rmid_results: valid=%h end=%0d required 00/0", hdr_valid_o, end_off_o);
    else passed++;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done_o) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL rmid_nodone: saw done_o=%b required 0", saw_done);
    else passed++;
    program_eth(20, 32'h0006_0002);
    start_pkt();
    wait_done(lat);
    checks++; if (hdr_valid_o !== 8'b0000_0111 || end_off_o !== 7'd54)
      $display("FAIL rmid_reparse: valid=%b end=%0d required 00000111/54", hdr_valid_o, end_off_o);
    else passed++;
  endtask

  task automatic test_busy_write();
    int lat;
    logic       exp_err;
    logic [6:0] exp_end;
    set_pkt(16'h0800);
    start_pkt();
    cfg_write(2, 40, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF); // lands mid-parse with commit
    wait_done(lat);
    checks++; if (end_off_o !== 7'd54 || err_o !== 1'b0)
      $display("FAIL busy_first: end=%0d err=%b required 54/0", end_off_o, err_o);
    else passed++;
`ifdef PS_CFG_SHADOW_EN
    exp_err = 1'b1;
    exp_end = 7'd34;
`else
    exp_err = 1'b0;
    exp_end = 7'd54;
`endif
    start_pkt();
    wait_done(lat);
    checks++; if (err_o !== exp_err)
      $display("FAIL busy_second_err: %b required %b", err_o, exp_err);
    else passed++;
    checks++; if (end_off_o !== exp_end)
      $display("FAIL busy_second_end: %0d required %0d", end_off_o, exp_end);
    else passed++;
  endtask

  initial begin
    rst              = 1'b1;
    start_i          = 1'b0;
    pkt_hdr_i        = '0;
    cfg_we_i         = 1'b0;
    cfg_hdr_id_i     = '0;
    cfg_hdr_len_i    = '0;
    cfg_tag_start_i  = '0;
    cfg_tag_len_i    = '0;
    cfg_next_table_i = '0;
    cfg_commit_i     = 1'b0;
    @(posedge clk); #1;
    test_reset();
    program_eth(20, 32'h0006_0002);
    test_chain();
    test_overrun();
    test_loop_guard();
    test_no_match();
    test_reset_mid();
    test_busy_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
